// File: rtl/fetch_queue.sv
// Prefetch instruction queue: issues in-order requests to a variable-latency
// instruction memory and buffers {instr, pc, err} for decode.
module fetch_queue #(
  parameter int unsigned      DW       = 16,
  parameter int unsigned      AW       = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [AW-1:0]    RESET_PC = '0,
  parameter int unsigned      INC      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_next,
  output logic          out_err
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Stale responses can pile up across back-to-back redirects; sized for the
  // memory's own in-flight capacity rather than for DEPTH.
  localparam int unsigned DrW = 8;

  logic [AW-1:0]  r_fetch_pc;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_outstanding;
  logic [DrW-1:0] r_drop;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [DW-1:0]  r_instr [DEPTH];
  logic [AW-1:0]  r_pc    [DEPTH];
  logic           r_err   [DEPTH];

  logic [CW:0]    w_credit_used;
  logic           w_gnt;
  logic           w_keep;
  logic           w_drop_rsp;
  logic           w_pop;
  logic [AW-1:0]  w_tail_pc;
  logic [AW-1:0]  w_fetch_pc_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_outstanding_nxt;
  logic [DrW-1:0] w_drop_nxt;
  logic [PW-1:0]  w_wptr_nxt;
  logic [PW-1:0]  w_rptr_nxt;

  // Credit covers both queued entries and live requests, so a kept response
  // always finds a free slot.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req      = rst & ~halt & (w_credit_used < (CW + 1)'(DEPTH));
  assign imem_addr     = r_fetch_pc;

  assign w_gnt      = imem_req & imem_gnt;
  assign w_drop_rsp = imem_rvalid & (r_drop != '0);
  assign w_keep     = imem_rvalid & (r_drop == '0);
  assign w_pop      = (r_count != '0) & out_ready;
  // Oldest live request's PC: the one this response belongs to.
  assign w_tail_pc  = r_fetch_pc - (AW'(r_outstanding) * AW'(INC));

  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop;
    w_wptr_nxt        = r_wptr;
    w_rptr_nxt        = r_rptr;
    if (redirect) begin
      w_fetch_pc_nxt    = redirect_pc;
      w_count_nxt       = '0;
      w_outstanding_nxt = '0;
      w_wptr_nxt        = '0;
      w_rptr_nxt        = '0;
      w_drop_nxt        = r_drop + DrW'(r_outstanding) + DrW'(w_gnt) - DrW'(imem_rvalid);
    end else begin
      if (w_gnt) w_fetch_pc_nxt = r_fetch_pc + AW'(INC);
      w_outstanding_nxt = r_outstanding + CW'(w_gnt) - CW'(w_keep);
      if (w_drop_rsp) w_drop_nxt = r_drop - DrW'(1);
      if (w_keep) w_wptr_nxt = r_wptr + PW'(1);
      if (w_pop) w_rptr_nxt = r_rptr + PW'(1);
      w_count_nxt = r_count + CW'(w_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
      r_wptr        <= w_wptr_nxt;
      r_rptr        <= w_rptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= RESET_PC;
        r_err[i]   <= 1'b0;
      end
    end else if (w_keep && !redirect) begin
      r_instr[r_wptr] <= imem_rdata;
      r_pc[r_wptr]    <= w_tail_pc;
      r_err[r_wptr]   <= imem_err;
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_instr   = r_instr[r_rptr];
  assign out_pc      = r_pc[r_rptr];
  assign out_pc_next = r_pc[r_rptr] + AW'(INC);
  assign out_err     = out_valid & r_err[r_rptr];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory responder plus a stream-level model of
// the expected request and decode sequences, with directed and random phases.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        out_ready = 1'b0;

  logic        imem_req, out_valid, out_err;
  logic [15:0] imem_addr, out_instr, out_pc, out_pc_next;
  logic        w_imem_req, w_out_valid, w_out_err;
  logic [15:0] w_imem_addr, w_out_instr, w_out_pc, w_out_pc_next;

  fetch_queue #(.DW(16), .AW(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .INC(2)) u_dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_err(out_err)
  );

  // Same stimulus, different reset PC: its PCs trail the main DUT's by 4 modulo 2^16
  // until the first redirect.
  fetch_queue #(.DW(16), .AW(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFC), .INC(2)) u_dut_w (
    .clk(clk), .rst(rst), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .out_pc_next(w_out_pc_next), .out_err(w_out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc_n, epoch, live, q_cnt, last_due, lat_min, lat_max;
  logic [15:0] req_pc, exp_pc, err_addr;
  bit          chk_w;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic logic [15:0] f_instr(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; entered and left at a falling edge with control inputs preset.
  task automatic cyc();
    bit          exp_req, g, r, p;
    mreq_t       head, nw;
    int          lat;
    logic [15:0] pc_nx, w_pc, w_pc_nx, w_addr;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      imem_rvalid = 1'b1;
      imem_rdata  = f_instr(mq[0].addr);
      imem_err    = (mq[0].addr == err_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_err    = 1'b0;
    end
    #1;
    exp_req = !halt && (live < int'(DEPTH));
    p       = (q_cnt != 0) && out_ready && !redirect;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", {16'd0, imem_addr}, {16'd0, req_pc});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q_cnt != 0});
    if (p) begin
      pc_nx = exp_pc + 16'd2;
      chk("out_pc", {16'd0, out_pc}, {16'd0, exp_pc});
      chk("out_pc_next", {16'd0, out_pc_next}, {16'd0, pc_nx});
      chk("out_instr", {16'd0, out_instr}, {16'd0, f_instr(exp_pc)});
      chk("out_err", {31'd0, out_err}, {31'd0, exp_pc == err_addr});
    end
    if (chk_w) begin
      w_addr  = req_pc + 16'hFFFC;
      w_pc    = exp_pc + 16'hFFFC;
      w_pc_nx = exp_pc + 16'hFFFE;
      chk("w_imem_req", {31'd0, w_imem_req}, {31'd0, exp_req});
      if (exp_req) chk("w_imem_addr", {16'd0, w_imem_addr}, {16'd0, w_addr});
      if (p) begin
        chk("w_out_pc", {16'd0, w_out_pc}, {16'd0, w_pc});
        chk("w_out_pc_next", {16'd0, w_out_pc_next}, {16'd0, w_pc_nx});
      end
    end
    g = exp_req && imem_gnt;
    r = imem_rvalid;
    @(posedge clk);
    if (r) head = mq.pop_front();
    if (g) begin
      lat = int'($urandom_range(lat_max, lat_min));
      nw.addr  = req_pc;
      nw.due   = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
      nw.epoch = epoch;
      last_due = nw.due;
      mq.push_back(nw);
    end
    if (redirect) begin
      epoch++;
      req_pc = redirect_pc;
      exp_pc = redirect_pc;
      live   = 0;
      q_cnt  = 0;
    end else begin
      if (g) begin
        req_pc = req_pc + 16'd2;
        live++;
      end
      if (r && head.epoch == epoch) q_cnt++;
      if (p) begin
        q_cnt--;
        live--;
        exp_pc = exp_pc + 16'd2;
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    out_ready   = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_out_pc", {16'd0, out_pc}, 32'd0);
    chk("rst_w_out_pc", {16'd0, w_out_pc}, 32'h0000_FFFC);
    repeat (2) @(negedge clk);
    mq.delete();
    cyc_n    = 0;
    epoch    = 0;
    live     = 0;
    q_cnt    = 0;
    last_due = -1;
    req_pc   = 16'h0000;
    exp_pc   = 16'h0000;
    rst      = 1'b1;
  endtask

  initial begin
    err_addr = 16'h0001;
    chk_w    = 1'b0;
    lat_min  = 1;
    lat_max  = 1;

    // Streaming from reset with 1-cycle memory; wrap checked on the 0xFFFC instance.
    do_reset();
    chk_w     = 1'b1;
    imem_gnt  = 1'b1;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("t1_valid_c2", {31'd0, out_valid}, 32'd1);
    chk("t1_pc_c2", {16'd0, out_pc}, 32'd0);
    repeat (10) cyc();
    chk_w = 1'b0;

    // Backpressure: queue fills to DEPTH, requests stop, then drain in order.
    out_ready = 1'b0;
    repeat (10) cyc();
    #1;
    chk("t2_req_off", {31'd0, imem_req}, 32'd0);
    chk("t2_valid_held", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (12) cyc();

    // Redirect with two requests in flight on 3-cycle memory.
    do_reset();
    lat_min   = 3;
    lat_max   = 3;
    out_ready = 1'b1;
    imem_gnt  = 1'b1;
    repeat (2) cyc();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    cyc();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    repeat (14) cyc();

    // Redirect coinciding with a grant and a response.
    lat_min = 1;
    lat_max = 1;
    repeat (4) cyc();
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    cyc();
    redirect = 1'b0;
    repeat (10) cyc();

    // Halt mid-stream, redirect while halted, then resume.
    lat_min = 2;
    lat_max = 2;
    repeat (3) cyc();
    halt = 1'b1;
    repeat (6) cyc();
    halt = 1'b0;
    repeat (6) cyc();
    halt = 1'b1;
    repeat (2) cyc();
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    cyc();
    redirect = 1'b0;
    repeat (3) cyc();
    halt = 1'b0;
    repeat (8) cyc();

    // Error on one response, then reset mid-stream and refetch from reset PC.
    do_reset();
    err_addr  = 16'h0006;
    lat_min   = 1;
    lat_max   = 1;
    imem_gnt  = 1'b1;
    out_ready = 1'b1;
    repeat (9) cyc();
    do_reset();
    err_addr  = 16'h0001;
    imem_gnt  = 1'b1;
    out_ready = 1'b1;
    repeat (6) cyc();

    // Random traffic.
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      imem_gnt    = ($urandom_range(3, 0) != 0);
      out_ready   = ($urandom_range(2, 0) != 0);
      halt        = ($urandom_range(9, 0) == 0);
      redirect    = ($urandom_range(24, 0) == 0);
      redirect_pc = 16'($urandom()) & 16'hFFFE;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
